// File: rtl/vx_index_buffer_arbiter_if.sv
// Bundle of requester, release/response and index-buffer signals around the arbiter.
// Latency: none, wiring only.
// Backpressure: carried by req_ready, rel_ready and rsp_ready.
interface vx_index_buffer_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SIZE     = 8,
  parameter int ADDRW    = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int REQW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      alloc_valid;
  logic [ADDRW-1:0]          alloc_tag;
  logic [REQW-1:0]           alloc_req_idx;
  logic                      rel_valid;
  logic [ADDRW-1:0]          rel_tag;
  logic                      rel_ready;
  logic                      rel_err;
  logic                      rsp_valid;
  logic [DATAW-1:0]          rsp_data;
  logic [REQW-1:0]           rsp_req_idx;
  logic                      rsp_ready;
  logic                      ib_acquire_en;
  logic [ADDRW-1:0]          ib_write_addr;
  logic [DATAW-1:0]          ib_write_data;
  logic                      ib_release_en;
  logic [ADDRW-1:0]          ib_read_addr;
  logic [DATAW-1:0]          ib_read_data;
  logic                      ib_full;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, rel_valid, rel_tag, rsp_ready,
           ib_write_addr, ib_read_data, ib_full,
    output req_ready, alloc_valid, alloc_tag, alloc_req_idx, rel_ready, rel_err,
           rsp_valid, rsp_data, rsp_req_idx, ib_acquire_en, ib_write_data,
           ib_release_en, ib_read_addr
  );

  // Requesters, response consumer and buffer side.
  modport master (
    output req_valid, req_data, rel_valid, rel_tag, rsp_ready,
           ib_write_addr, ib_read_data, ib_full,
    input  req_ready, alloc_valid, alloc_tag, alloc_req_idx, rel_ready, rel_err,
           rsp_valid, rsp_data, rsp_req_idx, ib_acquire_en, ib_write_data,
           ib_release_en, ib_read_addr
  );
endinterface

// File: rtl/vx_index_buffer_arbiter.sv
// Round-robin sharing of one index buffer among NUM_REQS requesters with per-requester caps and tag ownership.
// Latency: grant same cycle, alloc_* one cycle after grant; rsp_* one cycle after an accepted release.
// Backpressure: requests stall on cap or ib_full; releases stall while an unconsumed rsp is held.
module vx_index_buffer_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 32,
  parameter int SIZE        = 8,
  parameter int MAX_PER_REQ = 4,
  parameter int ADDRW       = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int REQW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic clk,
  input logic reset_n,
  vx_index_buffer_arbiter_if.slave bus
);
  localparam int CNTW = $clog2(MAX_PER_REQ + 1);

  logic [REQW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQS-1:0][CNTW-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]                in_use_q, in_use_d;
  logic [SIZE-1:0][REQW-1:0]      owner_q, owner_d;
  logic                           alloc_valid_q, alloc_valid_d;
  logic [ADDRW-1:0]               alloc_tag_q, alloc_tag_d;
  logic [REQW-1:0]                alloc_req_idx_q, alloc_req_idx_d;
  logic                           rel_err_q, rel_err_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [DATAW-1:0]               rsp_data_q, rsp_data_d;
  logic [REQW-1:0]                rsp_req_idx_q, rsp_req_idx_d;

  logic [NUM_REQS-1:0] elig;
  logic [NUM_REQS-1:0] grant;
  logic                grant_vld;
  logic [REQW-1:0]     grant_idx;
  logic [REQW-1:0]     scan_idx;
  logic                rel_ready;
  logic                rel_fire;
  logic                tag_in_use;
  logic                rel_ok;
  logic [REQW-1:0]     rel_owner;

  // Round-robin pick among requesters that are below their cap, blocked entirely while the buffer is full.
  always_comb begin
    elig      = '0;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = bus.req_valid[i] && (cnt_q[i] < CNTW'(MAX_PER_REQ));
    end
    if (!bus.ib_full) begin
      for (int k = 0; k < NUM_REQS; k++) begin
        scan_idx = REQW'((int'(rr_ptr_q) + k) % NUM_REQS);
        if (!grant_vld && elig[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  // Release acceptance: the single response register must be free or draining this cycle.
  always_comb begin
    rel_ready  = !rsp_valid_q || bus.rsp_ready;
    rel_fire   = bus.rel_valid && rel_ready;
    tag_in_use = in_use_q[bus.rel_tag];
    rel_ok     = rel_fire && tag_in_use;
    rel_owner  = owner_q[bus.rel_tag];
  end

  // Next-state for arbitration, ownership, counters and the registered outputs.
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    in_use_d        = in_use_q;
    owner_d         = owner_q;
    alloc_valid_d   = grant_vld;
    alloc_tag_d     = alloc_tag_q;
    alloc_req_idx_d = alloc_req_idx_q;
    rel_err_d       = rel_fire && !tag_in_use;
    rsp_valid_d     = rsp_valid_q && !bus.rsp_ready;
    rsp_data_d      = rsp_data_q;
    rsp_req_idx_d   = rsp_req_idx_q;
    // A legal release and a grant to the same requester cancel out in its counter.
    for (int i = 0; i < NUM_REQS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_vld && grant_idx == REQW'(i)) cnt_d[i] = cnt_d[i] + CNTW'(1);
      if (rel_ok && rel_owner == REQW'(i))    cnt_d[i] = cnt_d[i] - CNTW'(1);
    end
    if (rel_ok) begin
      in_use_d[bus.rel_tag] = 1'b0;
      rsp_valid_d           = 1'b1;
      rsp_data_d            = bus.ib_read_data;
      rsp_req_idx_d         = rel_owner;
    end
    // The buffer never offers a tag freed this same cycle, so the grant update cannot collide with the release.
    if (grant_vld) begin
      rr_ptr_d                    = (grant_idx == REQW'(NUM_REQS - 1)) ? '0 : grant_idx + REQW'(1);
      in_use_d[bus.ib_write_addr] = 1'b1;
      owner_d[bus.ib_write_addr]  = grant_idx;
      alloc_tag_d                 = bus.ib_write_addr;
      alloc_req_idx_d             = grant_idx;
    end
  end

  // State and output registers, cleared asynchronously together with the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      in_use_q        <= '0;
      owner_q         <= '0;
      alloc_valid_q   <= 1'b0;
      alloc_tag_q     <= '0;
      alloc_req_idx_q <= '0;
      rel_err_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_req_idx_q   <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      in_use_q        <= in_use_d;
      owner_q         <= owner_d;
      alloc_valid_q   <= alloc_valid_d;
      alloc_tag_q     <= alloc_tag_d;
      alloc_req_idx_q <= alloc_req_idx_d;
      rel_err_q       <= rel_err_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_req_idx_q   <= rsp_req_idx_d;
    end
  end

  assign bus.req_ready     = grant;
  assign bus.ib_acquire_en = grant_vld;
  assign bus.ib_write_data = grant_vld ? bus.req_data[int'(grant_idx)*DATAW +: DATAW] : '0;
  assign bus.ib_release_en = rel_ok;
  assign bus.ib_read_addr  = bus.rel_tag;
  assign bus.rel_ready     = rel_ready;
  assign bus.rel_err       = rel_err_q;
  assign bus.alloc_valid   = alloc_valid_q;
  assign bus.alloc_tag     = alloc_tag_q;
  assign bus.alloc_req_idx = alloc_req_idx_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_req_idx   = rsp_req_idx_q;
endmodule

// File: tb/tb_vx_index_buffer_arbiter.sv
// Bench for vx_index_buffer_arbiter with a lowest-free-tag index buffer model.
// Latency: expectations queued at issue, checked when alloc/rsp/rel_err appear.
// Backpressure: rsp_ready driven from the stimulus to stall and drain responses.
module tb_vx_index_buffer_arbiter;
  localparam int NUM_REQS = 4;
  localparam int DATAW    = 32;
  localparam int SIZE     = 8;
  localparam int MAXR     = 4;
  localparam int ADDRW    = 3;
  localparam int REQW     = 2;

  typedef struct packed { logic [ADDRW-1:0] tag; logic [REQW-1:0] idx; } alloc_exp_t;
  typedef struct packed { logic [DATAW-1:0] data; logic [REQW-1:0] idx; } rsp_exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  alloc_exp_t exp_alloc[$];
  rsp_exp_t   exp_rsp[$];
  int         exp_err[$];

  vx_index_buffer_arbiter_if #(.NUM_REQS(NUM_REQS), .DATAW(DATAW), .SIZE(SIZE)) bus ();

  vx_index_buffer_arbiter #(
    .NUM_REQS(NUM_REQS), .DATAW(DATAW), .SIZE(SIZE), .MAX_PER_REQ(MAXR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index buffer model: lowest free tag, full flag and free list registered, async read.
  logic [SIZE-1:0]  bf_used;
  logic [DATAW-1:0] bf_mem [SIZE];
  logic [ADDRW-1:0] bf_addr;
  logic             bf_found;

  always_comb begin
    bf_addr  = '0;
    bf_found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (!bf_found && !bf_used[i]) begin
        bf_found = 1'b1;
        bf_addr  = ADDRW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bf_used <= '0;
    else begin
      if (bus.ib_release_en) bf_used[bus.ib_read_addr] <= 1'b0;
      if (bus.ib_acquire_en) bf_used[bus.ib_write_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ib_acquire_en) bf_mem[bus.ib_write_addr] <= bus.ib_write_data;
  end

  assign bus.ib_full       = &bf_used;
  assign bus.ib_write_addr = bf_addr;
  assign bus.ib_read_data  = bf_mem[bus.ib_read_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output seen with no expectation queued", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_alloc(input int tag, input int idx);
    alloc_exp_t e;
    e.tag = ADDRW'(tag);
    e.idx = REQW'(idx);
    exp_alloc.push_back(e);
  endtask

  task automatic push_rsp(input logic [DATAW-1:0] data, input int idx);
    rsp_exp_t e;
    e.data = data;
    e.idx  = REQW'(idx);
    exp_rsp.push_back(e);
  endtask

  task automatic set_slot(input int i, input logic [DATAW-1:0] v);
    bus.req_data[i*DATAW +: DATAW] = v;
  endtask

  // Monitor: pops expectations on the falling edge whenever the DUT presents a result.
  always @(negedge clk) begin
    alloc_exp_t ea;
    rsp_exp_t   er;
    if (reset_n && bus.alloc_valid) begin
      if (exp_alloc.size() == 0) unexpected("alloc");
      else begin
        ea = exp_alloc.pop_front();
        chk("alloc_tag", 64'(bus.alloc_tag), 64'(ea.tag));
        chk("alloc_req_idx", 64'(bus.alloc_req_idx), 64'(ea.idx));
      end
    end
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_rsp.size() == 0) unexpected("rsp");
      else begin
        er = exp_rsp.pop_front();
        chk("rsp_data", 64'(bus.rsp_data), 64'(er.data));
        chk("rsp_req_idx", 64'(bus.rsp_req_idx), 64'(er.idx));
      end
    end
    if (reset_n && bus.rel_err) begin
      if (exp_err.size() == 0) unexpected("rel_err");
      else void'(exp_err.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rel_valid = 1'b0;
    bus.rel_tag   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_alloc_valid", 64'(bus.alloc_valid), 0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_rel_err", 64'(bus.rel_err), 0);
    chk("rst_rel_ready", 64'(bus.rel_ready), 1);
    chk("rst_acquire_en", 64'(bus.ib_acquire_en), 0);
    reset_n = 1'b1;
    tick();

    // Round-robin: all four requesting, grants 0,1,2,3,0 on tags 0..4.
    for (int i = 0; i < NUM_REQS; i++) set_slot(i, 32'h100 + 32'(i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      chk("rr_req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      push_alloc(k, k % 4);
      tick();
    end
    bus.req_valid = '0;

    // Drain tags 0..4 back-to-back with rsp_ready high.
    for (int t = 0; t < 5; t++) begin
      bus.rel_valid = 1'b1;
      bus.rel_tag   = ADDRW'(t);
      #1;
      chk("drain_release_en", 64'(bus.ib_release_en), 1);
      push_rsp(32'h100 + 32'(t % 4), t % 4);
      tick();
    end
    bus.rel_valid = 1'b0;

    // Cap: req1 alone gets exactly MAXR grants, then one more after a release.
    set_slot(1, 32'h200);
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cap_req_ready", 64'(bus.req_ready), (k < MAXR) ? 64'h2 : 64'h0);
      if (k < MAXR) push_alloc(k, 1);
      tick();
    end
    bus.rel_valid = 1'b1;
    bus.rel_tag   = 3'd2;
    #1;
    chk("cap_blocked_during_release", 64'(bus.req_ready), 0);
    push_rsp(32'h200, 1);
    tick();
    bus.rel_valid = 1'b0;
    #1;
    chk("cap_regrant", 64'(bus.req_ready), 64'h2);
    push_alloc(2, 1);
    tick();
    bus.req_valid = '0;

    // Release: req2 payload DEADBEEF gets tag 4, released with rsp_ready low.
    set_slot(2, 32'hDEADBEEF);
    bus.req_valid = 4'b0100;
    #1;
    chk("rel_req_ready", 64'(bus.req_ready), 64'h4);
    push_alloc(4, 2);
    tick();
    bus.req_valid = '0;
    bus.rel_valid = 1'b1;
    bus.rel_tag   = 3'd4;
    bus.rsp_ready = 1'b0;
    push_rsp(32'hDEADBEEF, 2);
    tick();

    // Backpressure: response held, a pending release of tag 0 is refused.
    bus.rel_tag = 3'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 1);
      chk("bp_rsp_data", 64'(bus.rsp_data), 64'hDEADBEEF);
      chk("bp_rsp_req_idx", 64'(bus.rsp_req_idx), 2);
      chk("bp_rel_ready", 64'(bus.rel_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready_resume", 64'(bus.rel_ready), 1);
    chk("bp_release_en_resume", 64'(bus.ib_release_en), 1);
    push_rsp(32'h200, 1);
    tick();

    // Illegal release of tag 5.
    bus.rel_tag = 3'd5;
    #1;
    chk("ill_release_en", 64'(bus.ib_release_en), 0);
    chk("ill_rel_ready", 64'(bus.rel_ready), 1);
    exp_err.push_back(5);
    tick();
    bus.rel_valid = 1'b0;
    chk("ill_rel_err", 64'(bus.rel_err), 1);
    chk("ill_no_rsp", 64'(bus.rsp_valid), 0);

    // req1 holds 3 tags: exactly one more grant proves its counter was untouched.
    set_slot(1, 32'h201);
    bus.req_valid = 4'b0010;
    #1;
    chk("ill_cnt_grant", 64'(bus.req_ready), 64'h2);
    push_alloc(0, 1);
    tick();
    #1;
    chk("ill_cnt_capped", 64'(bus.req_ready), 0);
    tick();
    bus.req_valid = '0;

    // Fill: req0 takes tags 4..7, then the buffer is full even for an eligible req2.
    set_slot(0, 32'h300);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_req_ready", 64'(bus.req_ready), 64'h1);
      push_alloc(4 + k, 0);
      tick();
    end
    bus.req_valid = 4'b0101;
    #1;
    chk("full_req_ready", 64'(bus.req_ready), 0);
    chk("full_acquire_en", 64'(bus.ib_acquire_en), 0);
    tick();

    // Free tag 7; next cycle it goes to req2 (pointer sits past req0).
    bus.rel_valid = 1'b1;
    bus.rel_tag   = 3'd7;
    push_rsp(32'h300, 0);
    tick();
    bus.rel_valid = 1'b0;
    #1;
    chk("refill_req_ready", 64'(bus.req_ready), 64'h4);
    tick();
    #1;
    chk("burst_alloc_valid", 64'(bus.alloc_valid), 1);
    chk("burst_alloc_tag", 64'(bus.alloc_tag), 7);
    chk("burst_alloc_idx", 64'(bus.alloc_req_idx), 2);

    // Asynchronous reset mid-burst.
    #1;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("arst_alloc_valid", 64'(bus.alloc_valid), 0);
    chk("arst_alloc_tag", 64'(bus.alloc_tag), 0);
    chk("arst_alloc_idx", 64'(bus.alloc_req_idx), 0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("arst_rsp_data", 64'(bus.rsp_data), 0);
    chk("arst_rel_err", 64'(bus.rel_err), 0);
    chk("arst_acquire_en", 64'(bus.ib_acquire_en), 0);
    reset_n = 1'b1;
    tick();

    // After reset: pointer back at 0, tags start from 0 again.
    set_slot(3, 32'h400);
    bus.req_valid = 4'b1001;
    #1;
    chk("post_rst_grant0", 64'(bus.req_ready), 64'h1);
    push_alloc(0, 0);
    tick();
    #1;
    chk("post_rst_grant3", 64'(bus.req_ready), 64'h8);
    push_alloc(1, 3);
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    chk("alloc_queue_drained", 64'(exp_alloc.size()), 0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 0);
    chk("err_queue_drained", 64'(exp_err.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
